io_intr_responder: RTL and testbench
====================================

IO_INTR_RESPONDER -- requirements
Module: io_intr_responder

Interface
REQ-001 Parameter: RELOAD_DEFAULT, 32'd1000, timer reload value after reset.
REQ-002 sys_clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 io_cs  input  1  IO chip select from the CPU.
REQ-005 io_rd  input  1  IO read strobe, qualified by io_cs.
REQ-006 io_wr  input  1  IO write strobe, qualified by io_cs.
REQ-007 io_addr  input  32  byte address (CPU ALU output); only bits [5:2] decoded.
REQ-008 io_din  input  32  write data from the CPU.
REQ-009 io_dout  output  32  read data to the CPU.
REQ-010 ext_event  input  1  external event line, synchronous to sys_clk.
REQ-011 intr  output  1  interrupt request to the CPU.
REQ-012 int_ack  input  1  interrupt acknowledge from the CPU.

Function
REQ-013 Register map at io_addr[5:2]: 0 CTRL (RW; bit0 intr_en, bit1 tmr_en; other bits read 0), 1 STATUS (RO pending[3:0]; a write with io_din[31]=1 clears pending), 2 RELOAD (RW 32b), 3 COUNT (RO 32b), 4-15 SCRATCH0-11 (RW 32b).
REQ-014 Writes occur on the rising edge when io_cs & io_wr; io_rd is ignored during writes.
REQ-015 Reads are combinational: io_dout = selected register when io_cs & io_rd & ~io_wr, else 32'h0.
REQ-016 Writing RELOAD loads the same value into COUNT on the same edge.
REQ-017 Timer: when tmr_en=1 and RELOAD!=0, COUNT decrements each cycle; at COUNT==0 it reloads RELOAD and raises a one-cycle tmr_evt; reload period is RELOAD+1 cycles.
REQ-018 When tmr_en=0 or RELOAD==0, COUNT holds its value and no tmr_evt fires.
REQ-019 ext_evt is a rising-edge detect of ext_event, using a one-cycle delayed copy cleared at reset.
REQ-020 pending is a 4-bit counter: +tmr_evt +ext_evt -ack_dec each cycle, saturating at 15 and never below 0.
REQ-021 Simultaneous tmr_evt and ext_evt add 2; simultaneous increment and ack_dec net out in the same cycle.
REQ-022 A STATUS clear write has priority over all same-cycle increments and decrements; the result is 0.
REQ-023 Events are counted whether or not intr_en is set.
REQ-024 Interrupt FSM states:
  - IDLE: intr=0; go to REQ when intr_en & pending!=0.
  - REQ: intr=1; go to ACK when int_ack=1.
  - ACK: intr=0; ack_dec pulses on entry (one cycle, only if pending!=0); go to IDLE when int_ack=0.
REQ-025 Exactly one pending decrement per int_ack high period, regardless of pulse length.
REQ-026 If intr_en is cleared while in REQ, intr stays 1 until acknowledged; the handshake is never abandoned.
REQ-027 If pending is cleared while in REQ, the FSM still completes REQ->ACK->IDLE, with no decrement below 0.
REQ-028 int_ack while in IDLE is ignored.
REQ-029 intr is a registered FSM output; no combinational path from any input to intr.
REQ-030 Latency: a single event in IDLE with intr_en=1 increments pending at edge N+1 and drives intr=1 at edge N+2.

Reset
REQ-031 Reset values:
  - CTRL=0, pending=0, RELOAD=RELOAD_DEFAULT, COUNT=RELOAD_DEFAULT, SCRATCH=0.
  - FSM=IDLE, intr=0, ext_event delay register=0.
REQ-032 Reset asserted mid-handshake drops intr to 0 immediately (asynchronously) and discards pending.
REQ-033 No register update occurs while reset is high; io_dout follows REQ-015 using the reset values.

Verification
REQ-034 Reset then read all 16 addresses -> CTRL=0, STATUS=0, RELOAD=COUNT=1000, SCRATCH=0; intr=0.
REQ-035 Write SCRATCH5 (addr 0x24)=0xDEADBEEF, then read it back -> 0xDEADBEEF; unaddressed or deselected read -> 0.
REQ-036 Write RELOAD=3, CTRL=3 -> tmr_evt every 4 cycles; intr rises 2 cycles after the first evt; hold int_ack 5 cycles -> pending decrements exactly once; intr re-raises after int_ack falls if pending!=0.
REQ-037 Same-cycle tmr_evt and ext_event edge with pending=14 -> pending=15 (saturated); 20 more events with CTRL=2 -> pending stays 15, intr=0.
REQ-038 In REQ, write STATUS with bit31=1 and CTRL=0 -> pending=0, intr stays 1 until int_ack; after ack, pending=0 and FSM returns to IDLE.
REQ-039 Assert reset while intr=1 -> intr=0 before the next clock edge, pending=0, COUNT=1000.

Source files
------------

// File: rtl/io_intr_responder.sv
// io_intr_responder: memory-mapped interval timer with event counter and
// a level interrupt that uses a four-phase request/acknowledge handshake.
`default_nettype none

module io_intr_responder #(
  parameter logic [31:0] RELOAD_DEFAULT = 32'd1000
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        io_cs,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_din,
  output logic [31:0] io_dout,
  input  logic        ext_event,
  output logic        intr,
  input  logic        int_ack
);

  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_STATUS = 4'd1;
  localparam logic [3:0] ADDR_RELOAD = 4'd2;
  localparam logic [3:0] ADDR_COUNT  = 4'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        intr_q, intr_d;
  logic [1:0]  ctrl_q;
  logic [3:0]  pending_q, pending_d;
  logic [31:0] reload_q;
  logic [31:0] count_q;
  logic [31:0] scratch_q [12];
  logic        ext_q;

  logic [3:0]  addr_idx;
  logic        wr_en;
  logic        rd_en;
  logic        tmr_run;
  logic        tmr_evt;
  logic        ext_evt;
  logic        ack_dec;
  logic        status_clr;
  logic [4:0]  pend_sum;
  logic [31:0] rdata;
  logic        unused_addr_bits;

  assign addr_idx         = io_addr[5:2];
  assign unused_addr_bits = ^{io_addr[31:6], io_addr[1:0]};
  assign wr_en            = io_cs & io_wr;
  assign rd_en            = io_cs & io_rd & ~io_wr;
  assign tmr_run          = ctrl_q[1] && (reload_q != 32'd0);
  assign tmr_evt          = tmr_run && (count_q == 32'd0);
  assign ext_evt          = ext_event & ~ext_q;
  assign status_clr       = wr_en && (addr_idx == ADDR_STATUS) && io_din[31];

  // Handshake FSM; ack_dec fires on the REQ->ACK transition edge only.
  always_comb begin
    state_d = state_q;
    ack_dec = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctrl_q[0] && (pending_q != 4'd0)) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (int_ack) begin
          state_d = S_ACK;
          ack_dec = (pending_q != 4'd0);
        end
      end
      S_ACK: begin
        if (!int_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    intr_d = (state_d == S_REQ);
  end

  // Net the increments and the decrement first, then saturate at 15.
  always_comb begin
    pend_sum = {1'b0, pending_q} + {4'd0, tmr_evt} + {4'd0, ext_evt};
    if (ack_dec) begin
      pend_sum = pend_sum - 5'd1;
    end
    pending_d = (pend_sum > 5'd15) ? 4'hF : pend_sum[3:0];
    if (status_clr) begin
      pending_d = 4'd0;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      intr_q    <= 1'b0;
      pending_q <= 4'd0;
      ext_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      intr_q    <= intr_d;
      pending_q <= pending_d;
      ext_q     <= ext_event;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      ctrl_q   <= 2'd0;
      reload_q <= RELOAD_DEFAULT;
      count_q  <= RELOAD_DEFAULT;
      for (int i = 0; i < 12; i++) begin
        scratch_q[i] <= 32'd0;
      end
    end else begin
      if (wr_en && (addr_idx == ADDR_CTRL)) begin
        ctrl_q <= io_din[1:0];
      end
      if (wr_en && (addr_idx >= 4'd4)) begin
        scratch_q[addr_idx - 4'd4] <= io_din;
      end
      // A RELOAD write restarts the count and overrides this cycle's tick.
      if (wr_en && (addr_idx == ADDR_RELOAD)) begin
        reload_q <= io_din;
        count_q  <= io_din;
      end else if (tmr_run) begin
        count_q <= (count_q == 32'd0) ? reload_q : count_q - 32'd1;
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr_idx)
      ADDR_CTRL:   rdata = {30'd0, ctrl_q};
      ADDR_STATUS: rdata = {28'd0, pending_q};
      ADDR_RELOAD: rdata = reload_q;
      ADDR_COUNT:  rdata = count_q;
      default:     rdata = scratch_q[addr_idx - 4'd4];
    endcase
  end

  assign io_dout = rd_en ? rdata : 32'd0;
  assign intr    = intr_q;

endmodule

`default_nettype wire

// File: tb/tb_io_intr_responder.sv
// tb_io_intr_responder: directed and randomized checks of io_intr_responder
// against a cycle-level behavioural model of the register map and handshake.
`default_nettype none

module tb_io_intr_responder;

  logic        sys_clk;
  logic        reset;
  logic        io_cs, io_rd, io_wr;
  logic [31:0] io_addr, io_din;
  logic [31:0] io_dout;
  logic        ext_event;
  logic        intr;
  logic        int_ack;

  int vectors;
  int miscompares;

  io_intr_responder #(.RELOAD_DEFAULT(32'd1000)) dut (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .io_cs    (io_cs),
    .io_rd    (io_rd),
    .io_wr    (io_wr),
    .io_addr  (io_addr),
    .io_din   (io_din),
    .io_dout  (io_dout),
    .ext_event(ext_event),
    .intr     (intr),
    .int_ack  (int_ack)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Behavioural model: phase 0 = no request, 1 = requesting, 2 = acknowledged.
  logic [1:0]  m_ctrl;
  int          m_pend;
  logic [31:0] m_reload, m_count;
  logic [31:0] m_scr [12];
  logic        m_ext_prev;
  int          m_phase;
  logic        m_intr;

  task automatic model_reset();
    m_ctrl = 2'd0; m_pend = 0; m_reload = 32'd1000; m_count = 32'd1000;
    for (int i = 0; i < 12; i++) m_scr[i] = 32'd0;
    m_ext_prev = 1'b0; m_phase = 0; m_intr = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] addr);
    int k;
    k = int'(addr[5:2]);
    case (k)
      0: return {30'd0, m_ctrl};
      1: return 32'(m_pend);
      2: return m_reload;
      3: return m_count;
      default: return m_scr[k-4];
    endcase
  endfunction

  function automatic logic [31:0] m_dout();
    if (io_cs && io_rd && !io_wr) return m_read(io_addr);
    return 32'd0;
  endfunction

  // Advance model and DUT one clock, with inputs held as currently driven.
  task automatic tick();
    int k, np, nph;
    logic wr, et, ee, ad, ext_now;
    logic [31:0] nc, din;
    k = int'(io_addr[5:2]); wr = io_cs & io_wr; din = io_din; ext_now = ext_event;
    et = m_ctrl[1] && (m_reload != 0) && (m_count == 0);
    ee = ext_now && !m_ext_prev;
    ad = (m_phase == 1) && int_ack && (m_pend != 0);
    np = m_pend + int'(et) + int'(ee) - int'(ad);
    if (np > 15) np = 15;
    if (np < 0) np = 0;
    if (wr && k == 1 && din[31]) np = 0;
    nc = m_count;
    if (m_ctrl[1] && m_reload != 0) nc = (m_count == 0) ? m_reload : m_count - 1;
    if (wr && k == 2) nc = din;
    nph = m_phase;
    if (m_phase == 0 && m_ctrl[0] && m_pend != 0) nph = 1;
    else if (m_phase == 1 && int_ack) nph = 2;
    else if (m_phase == 2 && !int_ack) nph = 0;
    @(posedge sys_clk);
    if (wr && k == 0) m_ctrl = din[1:0];
    if (wr && k == 2) m_reload = din;
    if (wr && k >= 4) m_scr[k-4] = din;
    m_count = nc; m_pend = np; m_phase = nph; m_intr = (nph == 1);
    m_ext_prev = ext_now;
    #1;
  endtask

  task automatic bus_idle();
    io_cs = 0; io_rd = 0; io_wr = 0; io_addr = 0; io_din = 0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    io_cs = 1; io_wr = 1; io_rd = 0; io_addr = addr; io_din = data;
    tick();
    bus_idle();
  endtask

  task automatic bus_read_setup(input logic [31:0] addr);
    io_cs = 1; io_rd = 1; io_wr = 0; io_addr = addr; io_din = 0;
  endtask

  task automatic apply_reset();
    bus_idle(); ext_event = 0; int_ack = 0;
    reset = 1;
    @(posedge sys_clk); @(posedge sys_clk); #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    for (int a = 0; a < 16; a++) begin
      bus_read_setup(32'(a << 2));
      #1;
      vectors++;
      if (io_dout !== m_read(io_addr)) begin
        miscompares++;
        $display("FAIL reset_read addr=%0d got=%h exp=%h", a, io_dout, m_read(io_addr));
      end
      vectors++;
      if (intr !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_intr got=%b exp=0", intr);
      end
      tick();
    end
    bus_idle();
  endtask

  task automatic test_scratch();
    bus_write(32'h24, 32'hDEADBEEF);
    bus_read_setup(32'h24); #1;
    vectors++;
    if (io_dout !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL scratch5_read got=%h exp=deadbeef", io_dout);
    end
    io_cs = 0; #1;
    vectors++;
    if (io_dout !== 32'd0) begin
      miscompares++;
      $display("FAIL deselected_read got=%h exp=0", io_dout);
    end
    io_cs = 1; io_wr = 1; #1;
    vectors++;
    if (io_dout !== 32'd0) begin
      miscompares++;
      $display("FAIL read_during_write got=%h exp=0", io_dout);
    end
    bus_idle(); tick();
  endtask

  task automatic test_timer_handshake();
    int rise_seen;
    apply_reset();
    bus_write(32'h8, 32'd3);
    bus_write(32'h0, 32'd3);
    rise_seen = 0;
    for (int c = 0; c < 60; c++) begin
      bus_read_setup(32'h4);
      if (intr && rise_seen < 5) begin
        int_ack = 1; rise_seen++;
      end else if (rise_seen >= 5) begin
        int_ack = 0;
      end
      #1;
      vectors++;
      if (io_dout !== m_dout() || intr !== m_intr) begin
        miscompares++;
        $display("FAIL timer_cycle c=%0d status=%h exp=%h intr=%b exp=%b",
                 c, io_dout, m_dout(), intr, m_intr);
      end
      tick();
    end
    int_ack = 0;
    bus_idle();
  endtask

  task automatic test_saturation();
    int bound;
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      ext_event = 1; tick(); ext_event = 0; tick();
    end
    bus_read_setup(32'h4); #1;
    vectors++;
    if (io_dout !== 32'd14) begin
      miscompares++;
      $display("FAIL pending_14 got=%0d exp=14", io_dout);
    end
    bus_idle();
    bus_write(32'h8, 32'd3);
    bus_write(32'h0, 32'd2);
    bound = 0;
    while (m_count != 0 && bound < 10) begin
      tick(); bound++;
    end
    ext_event = 1; tick(); ext_event = 0;
    bus_read_setup(32'h4); #1;
    vectors++;
    if (io_dout !== 32'd15) begin
      miscompares++;
      $display("FAIL pending_sat got=%0d exp=15", io_dout);
    end
    for (int i = 0; i < 20; i++) begin
      tick(); ext_event = 1; tick(); ext_event = 0; #1;
      vectors++;
      if (io_dout !== 32'd15 || intr !== 1'b0) begin
        miscompares++;
        $display("FAIL sat_hold i=%0d pending=%0d exp=15 intr=%b exp=0", i, io_dout, intr);
      end
    end
    bus_idle(); tick();
  endtask

  task automatic test_clear_in_req();
    int bound;
    apply_reset();
    bus_write(32'h0, 32'd1);
    ext_event = 1; tick(); ext_event = 0;
    bound = 0;
    while (intr !== 1'b1 && bound < 10) begin
      tick(); bound++;
    end
    vectors++;
    if (intr !== 1'b1) begin
      miscompares++;
      $display("FAIL req_timeout intr=%b exp=1", intr);
    end
    bus_write(32'h4, 32'h8000_0000);
    bus_write(32'h0, 32'd0);
    bus_read_setup(32'h4); #1;
    vectors++;
    if (intr !== 1'b1 || io_dout !== 32'd0) begin
      miscompares++;
      $display("FAIL clear_in_req intr=%b exp=1 pending=%0d exp=0", intr, io_dout);
    end
    int_ack = 1;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) int_ack = 0;
      tick(); #1;
      vectors++;
      if (intr !== 1'b0 || io_dout !== 32'd0 || m_phase != (c < 3 ? 2 : 0)) begin
        miscompares++;
        $display("FAIL ack_after_clear c=%0d intr=%b exp=0 pending=%0d exp=0", c, intr, io_dout);
      end
    end
    bus_idle();
  endtask

  task automatic test_reset_mid_handshake();
    int bound;
    apply_reset();
    bus_write(32'h0, 32'd1);
    ext_event = 1; tick(); ext_event = 0;
    bound = 0;
    while (intr !== 1'b1 && bound < 10) begin
      tick(); bound++;
    end
    #1 reset = 1;
    #1;
    vectors++;
    if (intr !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_intr got=%b exp=0", intr);
    end
    bus_read_setup(32'hC); #1;
    vectors++;
    if (io_dout !== 32'd1000) begin
      miscompares++;
      $display("FAIL reset_count got=%0d exp=1000", io_dout);
    end
    io_addr = 32'h4; #1;
    vectors++;
    if (io_dout !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_pending got=%0d exp=0", io_dout);
    end
    bus_idle();
    @(posedge sys_clk); #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_random();
    int op;
    logic [31:0] a;
    apply_reset();
    bus_write(32'h8, 32'd5);
    bus_write(32'h0, 32'd3);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) ext_event = ~ext_event;
      if ($urandom_range(0, 3) == 0) int_ack = ~int_ack;
      op = $urandom_range(0, 9);
      a = $urandom;
      if (op == 0) begin
        io_cs = 1; io_wr = 1; io_rd = $urandom_range(0, 1); io_addr = a;
        case (a[5:2])
          4'd0: io_din = $urandom;
          4'd1: io_din = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'h0000_000F;
          4'd2: io_din = 32'($urandom_range(0, 6));
          default: io_din = $urandom;
        endcase
      end else begin
        io_cs = ($urandom_range(0, 7) != 0); io_rd = 1; io_wr = 0;
        io_addr = a; io_din = $urandom;
      end
      #1;
      vectors++;
      if (io_dout !== m_dout() || intr !== m_intr) begin
        miscompares++;
        $display("FAIL random c=%0d addr=%h dout=%h exp=%h intr=%b exp=%b",
                 c, io_addr, io_dout, m_dout(), intr, m_intr);
      end
      tick();
    end
    bus_idle(); int_ack = 0; ext_event = 0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    bus_idle(); ext_event = 0; int_ack = 0; reset = 0;
    model_reset();
    test_reset();
    test_scratch();
    test_timer_handshake();
    test_saturation();
    test_clear_in_req();
    test_reset_mid_handshake();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
